// File: rtl/mem_ahb_ws_if.sv
// AHB-Lite bus bundle between a manager and the mem_ahb_ws subordinate.
// HREADYin is the bus-level ready, driven by the interconnect/manager side.
interface mem_ahb_ws_if #(
   parameter int unsigned AddressWidth = 32,
   parameter int unsigned DataWidth    = 32
);
   logic                    HSEL;
   logic [AddressWidth-1:0] HADDR;
   logic [1:0]              HTRANS;
   logic                    HWRITE;
   logic [2:0]              HSIZE;
   logic [2:0]              HBURST;
   logic [DataWidth-1:0]    HWDATA;
   logic [DataWidth-1:0]    HRDATA;
   logic                    HRESP;
   logic                    HREADYin;
   logic                    HREADYout;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
      input  HRDATA, HRESP, HREADYout
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
      output HRDATA, HRESP, HREADYout
   );
endinterface

// File: rtl/mem_ahb_ws.sv
// AHB-Lite memory subordinate with lane steering, wait states and read-after-write forwarding.
// Define MEM_AHB_WS_ERR_EN to answer out-of-range/misaligned/illegal-size accesses with ERROR.
module mem_ahb_ws #(
   parameter int unsigned AddressWidth = 32,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned Depth        = 1024,
   parameter int unsigned WaitStates   = 0
) (
   input logic         HCLK,
   input logic         HRESETn,
   mem_ahb_ws_if.slave bus
);
   localparam int unsigned Bytes   = DataWidth / 8;
   localparam int unsigned LaneW   = $clog2(Bytes);
   localparam int unsigned IdxW    = $clog2(Depth);
   localparam logic [2:0]  MaxSize = 3'(LaneW);

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StData
`ifdef MEM_AHB_WS_ERR_EN
      ,
      StErr1,
      StErr2
`endif
   } state_e;

   state_e               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [Bytes-1:0]     strb_q, strb_d;
   logic                 write_q, write_d;
   logic [DataWidth-1:0] hrdata_q, hrdata_d;

   logic [DataWidth-1:0] mem [Depth];

   logic                 accept;
   logic [LaneW-1:0]     lane;
   logic [IdxW-1:0]      idx;
   logic [2:0]           size_eff;
   logic [Bytes-1:0]     strb;
   logic                 rd_load;
   logic [IdxW-1:0]      rd_idx;
   logic                 mem_we;
`ifdef MEM_AHB_WS_ERR_EN
   logic                 bad;
`endif

   logic [AddressWidth-1:0] unused_addr;
   logic                    unused_misc;
   assign unused_addr = bus.HADDR;
   assign unused_misc = ^{bus.HBURST, bus.HTRANS[0]};

   // Address-phase decode; illegal sizes fall back to full width, low bits are force-aligned.
   always_comb begin
      lane     = bus.HADDR[LaneW-1:0];
      idx      = bus.HADDR[LaneW +: IdxW];
      size_eff = (bus.HSIZE > MaxSize) ? MaxSize : bus.HSIZE;
      strb     = '0;
      for (int unsigned b = 0; b < Bytes; b++) begin
         strb[b] = ((b >> size_eff) == (32'(lane) >> size_eff));
      end
`ifdef MEM_AHB_WS_ERR_EN
      bad = (64'(bus.HADDR) >= (64'(Depth) * 64'(Bytes))) ||
            (bus.HSIZE > MaxSize) ||
            ((32'(lane) & ((32'd1 << bus.HSIZE) - 32'd1)) != 32'd0);
`endif
   end

   always_comb begin
      accept  = bus.HSEL & bus.HREADYin & bus.HTRANS[1];
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      strb_d  = strb_q;
      write_d = write_q;
      rd_load = 1'b0;
      rd_idx  = idx_q;
      unique case (state_q)
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StData;
               rd_load = ~write_q;
            end
         end
`ifdef MEM_AHB_WS_ERR_EN
         StErr1: state_d = StErr2;
`endif
         default: begin
            // Idle, data and second error cycle all present HREADYout=1 and may accept.
            state_d = StIdle;
            if (accept) begin
               idx_d   = idx;
               strb_d  = strb;
               write_d = bus.HWRITE;
`ifdef MEM_AHB_WS_ERR_EN
               if (bad) begin
                  state_d = StErr1;
               end else
`endif
               if (WaitStates == 0) begin
                  state_d = StData;
                  rd_load = ~bus.HWRITE;
                  rd_idx  = idx;
               end else begin
                  state_d = StWait;
                  cnt_d   = 4'(WaitStates);
               end
            end
         end
      endcase
   end

   // Read data is captured as the data phase begins; a write in its data phase to the
   // same word commits on that same edge, so its lanes are merged in here.
   always_comb begin
      hrdata_d = hrdata_q;
      if (rd_load) begin
         hrdata_d = mem[rd_idx];
         if ((state_q == StData) && write_q && (idx_q == rd_idx)) begin
            for (int unsigned b = 0; b < Bytes; b++) begin
               if (strb_q[b]) begin
                  hrdata_d[8*b +: 8] = bus.HWDATA[8*b +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         idx_q    <= '0;
         strb_q   <= '0;
         write_q  <= 1'b0;
         hrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         strb_q   <= strb_d;
         write_q  <= write_d;
         hrdata_q <= hrdata_d;
      end
   end

   assign mem_we = (state_q == StData) && write_q;

   always_ff @(posedge HCLK) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < Bytes; b++) begin
            if (strb_q[b]) begin
               mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      bus.HRDATA    = hrdata_q;
      bus.HREADYout = (state_q != StWait);
      bus.HRESP     = 1'b0;
`ifdef MEM_AHB_WS_ERR_EN
      if (state_q == StErr1) begin
         bus.HREADYout = 1'b0;
      end
      bus.HRESP = (state_q == StErr1) || (state_q == StErr2);
`endif
   end
endmodule

// File: tb/tb_mem_ahb_ws.sv
// Bench for mem_ahb_ws: a 32-bit zero-wait instance and a 64-bit three-wait instance share
// one pipelined manager; a byte-addressed model predicts HREADYout/HRESP/HRDATA each cycle.
module tb_mem_ahb_ws;
   typedef struct {
      bit          vld;
      bit          wr;
      bit          seq;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [63:0] wdata;
   } op_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bit          sel;
   logic        m_sel;
   logic [1:0]  m_trans;
   logic [31:0] m_addr;
   logic        m_write;
   logic [2:0]  m_size;
   logic [63:0] m_wdata;

   mem_ahb_ws_if #(.AddressWidth(32), .DataWidth(32)) ia ();
   mem_ahb_ws_if #(.AddressWidth(32), .DataWidth(64)) ib ();

   assign ia.HSEL     = m_sel & ~sel;
   assign ia.HADDR    = m_addr;
   assign ia.HTRANS   = m_trans;
   assign ia.HWRITE   = m_write;
   assign ia.HSIZE    = m_size;
   assign ia.HBURST   = 3'd0;
   assign ia.HWDATA   = m_wdata[31:0];
   assign ia.HREADYin = ia.HREADYout;

   assign ib.HSEL     = m_sel & sel;
   assign ib.HADDR    = m_addr;
   assign ib.HTRANS   = m_trans;
   assign ib.HWRITE   = m_write;
   assign ib.HSIZE    = m_size;
   assign ib.HBURST   = 3'd3;
   assign ib.HWDATA   = m_wdata;
   assign ib.HREADYin = ib.HREADYout;

   mem_ahb_ws #(.AddressWidth(32), .DataWidth(32), .Depth(1024), .WaitStates(0)) u_a (
      .HCLK    (clk),
      .HRESETn (rst_n),
      .bus     (ia)
   );

   mem_ahb_ws #(.AddressWidth(32), .DataWidth(64), .Depth(1024), .WaitStates(3)) u_b (
      .HCLK    (clk),
      .HRESETn (rst_n),
      .bus     (ib)
   );

   logic        rdy, resp;
   logic [63:0] rdata;
   always_comb begin
      rdy   = sel ? ib.HREADYout : ia.HREADYout;
      resp  = sel ? ib.HRESP : ia.HRESP;
      rdata = sel ? ib.HRDATA : {32'd0, ia.HRDATA};
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model state: byte memory per instance, plus observed per-run statistics.
   logic [7:0]  mdl [int];
   bit          chk_en = 1'b0;
   int          nrdy_cnt, resp_cyc;
   logic [63:0] last_rd;

   function automatic int key(input int a);
      return (sel ? 65536 : 0) + a;
   endfunction

   bit          cur_v = 1'b0;
   bit          cur_wr, cur_err;
   int          cur_base, cur_n, wleft;

   always begin : p_check
      int          bytes, maxsz, span, s, wb;
      logic [63:0] e, mk;
      @(negedge clk);
      #1;
      if (!chk_en) begin
         cur_v = 1'b0;
      end else begin
         bytes = sel ? 8 : 4;
         maxsz = sel ? 3 : 2;
         span  = 1024 * bytes;
         if (!rdy) nrdy_cnt++;
         if (resp) resp_cyc++;
         if (cur_v) begin
            if (wleft > 0) begin
               chk("wait_hready", rdy, 0);
               chk("wait_hresp", resp, cur_err);
               wleft--;
            end else begin
               chk("data_hready", rdy, 1);
               chk("data_hresp", resp, cur_err);
               if (!cur_err && !cur_wr) begin
                  e  = '0;
                  mk = '0;
                  wb = cur_base - (cur_base % bytes);
                  for (int b = 0; b < bytes; b++) begin
                     if (mdl.exists(key(wb + b))) begin
                        e[8*b +: 8]  = mdl[key(wb + b)];
                        mk[8*b +: 8] = 8'hFF;
                     end
                  end
                  chk("hrdata", rdata & mk, e);
                  last_rd = rdata;
               end else if (!cur_err) begin
                  for (int k = cur_base; k < cur_base + cur_n; k++) begin
                     mdl[key(k)] = m_wdata[8*(k % bytes) +: 8];
                  end
               end
               cur_v = 1'b0;
            end
         end else begin
            chk("idle_hready", rdy, 1);
            chk("idle_hresp", resp, 0);
         end
         // A new address phase is taken at the coming edge.
         if (m_sel && m_trans[1] && rdy) begin
            cur_v   = 1'b1;
            cur_wr  = m_write;
            cur_err = 1'b0;
`ifdef MEM_AHB_WS_ERR_EN
            cur_err = (m_addr >= 32'(span)) || (int'(m_size) > maxsz) ||
                      ((m_addr % (32'd1 << m_size)) != 0);
`endif
            s        = (int'(m_size) > maxsz) ? maxsz : int'(m_size);
            cur_base = int'(m_addr % 32'(span));
            cur_base = cur_base - (cur_base % (1 << s));
            cur_n    = 1 << s;
            wleft    = cur_err ? 1 : (sel ? 3 : 0);
         end
      end
   end

   op_t ops[$];

   task automatic push(input bit vld, input bit wr, input bit seq, input logic [31:0] a,
                       input logic [2:0] sz, input logic [63:0] d);
      op_t o;
      o.vld = vld; o.wr = wr; o.seq = seq; o.addr = a; o.size = sz; o.wdata = d;
      ops.push_back(o);
   endtask

   task automatic drive(input int i);
      m_sel = 1'b1;
      if (i < ops.size() && ops[i].vld) begin
         m_trans = ops[i].seq ? 2'b11 : 2'b10;
         m_addr  = ops[i].addr;
         m_write = ops[i].wr;
         m_size  = ops[i].size;
      end else begin
         m_trans = 2'b00;
      end
   endtask

   // Pipelined manager: address advances and write data follows only after a ready edge.
   task automatic run_ops();
      int ai, cyc;
      bit hr;
      ai = 0;
      cyc = 0;
      nrdy_cnt = 0;
      resp_cyc = 0;
      @(negedge clk);
      chk_en = 1'b1;
      drive(0);
      hr = rdy;
      while (ai < ops.size()) begin
         @(negedge clk);
         if (hr) begin
            m_wdata = ops[ai].wdata;
            ai++;
            drive(ai);
         end
         hr = rdy;
         cyc++;
         if (cyc > 500) begin
            n_vec++;
            n_bad++;
            $display("FAIL run_timeout: got HREADYout stuck, expected progress (t=%0t)", $time);
            break;
         end
      end
      repeat (8) @(negedge clk);
      chk_en = 1'b0;
      m_sel  = 1'b0;
      ops.delete();
   endtask

   initial begin
      rst_n   = 1'b0;
      sel     = 1'b0;
      m_sel   = 1'b0;
      m_trans = 2'b00;
      m_addr  = '0;
      m_write = 1'b0;
      m_size  = 3'd0;
      m_wdata = '0;
      last_rd = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_a_hready", ia.HREADYout, 1);
      chk("rst_a_hresp", ia.HRESP, 0);
      chk("rst_a_hrdata", ia.HRDATA, 0);
      chk("rst_b_hready", ib.HREADYout, 1);
      chk("rst_b_hresp", ib.HRESP, 0);
      chk("rst_b_hrdata", ib.HRDATA, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 32-bit, zero wait states.
      push(0, 0, 0, 0, 0, 0); push(0, 0, 0, 0, 0, 0); push(0, 0, 0, 0, 0, 0);
      run_ops();
      chk("idle_no_stall", nrdy_cnt, 0);

      push(1, 1, 0, 32'h10, 3'd2, 64'hDEADBEEF);
      push(1, 1, 0, 32'h12, 3'd0, 64'h00A50000);
      push(1, 0, 0, 32'h10, 3'd2, 64'h0);
      run_ops();
      chk("fwd_byte_merge", last_rd, 64'hDEA5BEEF);
      chk("fwd_no_stall", nrdy_cnt, 0);

      push(1, 1, 0, 32'h20, 3'd2, 64'h11223344);
      push(1, 1, 0, 32'h22, 3'd1, 64'hCAFE0000);
      push(1, 0, 0, 32'h20, 3'd2, 64'h0);
      run_ops();
      chk("fwd_half_merge", last_rd, 64'hCAFE3344);

      push(0, 0, 0, 0, 0, 0);
      push(1, 0, 0, 32'h23, 3'd0, 64'h0);
      push(1, 0, 0, 32'h20, 3'd3, 64'h0);
      push(1, 1, 0, 32'h24, 3'd3, 64'h55667788);
      push(0, 0, 0, 0, 0, 0);
      push(1, 0, 0, 32'h24, 3'd2, 64'h0);
      run_ops();
`ifdef MEM_AHB_WS_ERR_EN
      chk("illegal_size_err_cycles", resp_cyc, 4);
`else
      chk("illegal_size_full_word", last_rd, 64'h55667788);
`endif

      push(1, 1, 0, 32'h0, 3'd2, 64'h0BADF00D);
      run_ops();
      push(1, 0, 0, 32'h1000, 3'd2, 64'h0);
      push(1, 0, 0, 32'h2, 3'd2, 64'h0);
      run_ops();
`ifdef MEM_AHB_WS_ERR_EN
      chk("err_resp_cycles", resp_cyc, 4);
      chk("err_stall_cycles", nrdy_cnt, 2);
`else
      chk("wrap_aligned_read", last_rd, 64'h0BADF00D);
      chk("no_err_resp", resp_cyc, 0);
`endif

      // 64-bit, three wait states.
      sel = 1'b1;
      push(1, 1, 0, 32'h0, 3'd3, 64'h8877665544332211);
      run_ops();
      push(1, 0, 0, 32'h4, 3'd2, 64'h0);
      run_ops();
      chk("ws3_single_waits", nrdy_cnt, 3);
      chk("ws3_single_data", last_rd, 64'h8877665544332211);

      push(1, 1, 0, 32'h6, 3'd1, 64'h1234000000000000);
      push(1, 0, 0, 32'h0, 3'd3, 64'h0);
      run_ops();
      chk("dw64_half_lane", last_rd, 64'h1234665544332211);

      push(1, 0, 0, 32'h0, 3'd3, 64'h0);
      push(1, 0, 1, 32'h8, 3'd3, 64'h0);
      push(1, 0, 1, 32'h10, 3'd3, 64'h0);
      push(1, 0, 1, 32'h18, 3'd3, 64'h0);
      run_ops();
      chk("burst4_wait_cycles", nrdy_cnt, 12);

      // Reset while a write is still waiting: it must never reach the array.
      @(negedge clk);
      m_sel = 1'b1; m_trans = 2'b10; m_addr = 32'h0; m_write = 1'b1; m_size = 3'd3;
      @(negedge clk);
      m_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      m_trans = 2'b00;
      #1;
      chk("pre_rst_in_wait", ib.HREADYout, 0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_abort_hready", ib.HREADYout, 1);
      chk("rst_abort_hresp", ib.HRESP, 0);
      chk("rst_abort_hrdata", ib.HRDATA, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_sel = 1'b0;
      push(1, 0, 0, 32'h0, 3'd3, 64'h0);
      run_ops();
      chk("rst_write_dropped", last_rd, 64'h1234665544332211);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
